// File: rtl/mul_share_arb2.sv
// Two-requester front end for one shared N-bit multiplier: round-robin grant
// into a single registered result slot with a valid/ready output channel.
module mul_share_arb2 #(
    parameter int unsigned n = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [n-1:0]   req0_a,
    input  logic [n-1:0]   req0_b,
    input  logic           req0_sign,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [n-1:0]   req1_a,
    input  logic [n-1:0]   req1_b,
    input  logic           req1_sign,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*n-1:0] res,
    output logic           res_id
);

    // Handshakes: a transfer happens on a channel when valid && ready at a
    // rising edge; ready may depend on valid, valid must not depend on ready.

    logic           prio_q, prio_d;
    logic           res_valid_q, res_valid_d;
    logic [2*n-1:0] res_q, res_d;
    logic           res_id_q, res_id_d;

    logic           free;
    logic           gnt0, gnt1;
    logic [n-1:0]   mul_a, mul_b;
    logic           mul_sign;
    logic [2*n-1:0] ext_a, ext_b;
    logic [2*n-1:0] prod;

    assign free = !res_valid_q || res_ready;

    // Contention is resolved by the pointer, which names the preferred requester.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (free) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Operand mux for the single multiplier; requester 1 only when it won.
    always_comb begin
        mul_a    = req0_a;
        mul_b    = req0_b;
        mul_sign = req0_sign;
        if (gnt1) begin
            mul_a    = req1_a;
            mul_b    = req1_b;
            mul_sign = req1_sign;
        end
    end

    // Extending both operands to 2n and keeping the low 2n product bits gives
    // the exact signed or unsigned product without a signed multiplier.
    always_comb begin
        ext_a = {{n{1'b0}}, mul_a};
        ext_b = {{n{1'b0}}, mul_b};
        if (mul_sign) begin
            ext_a = {{n{mul_a[n-1]}}, mul_a};
            ext_b = {{n{mul_b[n-1]}}, mul_b};
        end
    end

    assign prod = ext_a * ext_b;

    always_comb begin
        prio_d      = prio_q;
        res_valid_d = res_valid_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        if (gnt0 || gnt1) begin
            prio_d      = gnt0;
            res_valid_d = 1'b1;
            res_d       = prod;
            res_id_d    = gnt1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            res_id_q    <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res       = res_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_mul_share_arb2.sv
// Directed bench for mul_share_arb2 at n=4 with hand-computed products.
module tb_mul_share_arb2;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req0_ready, req0_sign;
    logic [N-1:0]   req0_a, req0_b;
    logic           req1_valid, req1_ready, req1_sign;
    logic [N-1:0]   req1_a, req1_b;
    logic           res_valid, res_ready, res_id;
    logic [2*N-1:0] res;

    int n_vec;
    int n_err;

    mul_share_arb2 #(.n(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sign  (req0_sign),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sign  (req1_sign),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res        (res),
        .res_id     (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        req0_valid = v; req0_a = a; req0_b = b; req0_sign = s;
    endtask

    task automatic drive1(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        req1_valid = v; req1_a = a; req1_b = b; req1_sign = s;
    endtask

    // Inputs are driven 1 time unit after a rising edge; this checks the
    // combinational readies, then crosses one edge and checks the slot.
    task automatic cycle(input string tag, input logic exp_r0, input logic exp_r1,
                         input logic exp_v, input logic [2*N-1:0] exp_res, input logic exp_id);
        #1;
        check_eq({tag, ".ready0"}, 16'(req0_ready), 16'(exp_r0));
        check_eq({tag, ".ready1"}, 16'(req1_ready), 16'(exp_r1));
        @(posedge clk);
        #1;
        check_eq({tag, ".valid"}, 16'(res_valid), 16'(exp_v));
        check_eq({tag, ".res"},   16'(res),       16'(exp_res));
        check_eq({tag, ".id"},    16'(res_id),    16'(exp_id));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        res_ready = 1'b0;
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.valid", 16'(res_valid), 16'd0);
        check_eq("rst.res",   16'(res),       16'd0);
        check_eq("rst.id",    16'(res_id),    16'd0);
        rst_n = 1'b1;

        // Single requester, unsigned 15*15
        res_ready = 1'b1;
        drive0(1'b1, 4'hF, 4'hF, 1'b0);
        cycle("uns_ff", 1'b1, 1'b0, 1'b1, 8'hE1, 1'b0);

        // Signed extremes from requester 1
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b1, 4'h8, 4'h8, 1'b1);
        cycle("s_m8m8", 1'b0, 1'b1, 1'b1, 8'h40, 1'b1);
        drive1(1'b1, 4'h8, 4'h7, 1'b1);
        cycle("s_m8p7", 1'b0, 1'b1, 1'b1, 8'hC8, 1'b1);

        // Per-request sign mode, same operands
        drive1(1'b0, '0, '0, 1'b0);
        drive0(1'b1, 4'hF, 4'hF, 1'b1);
        cycle("mode_s", 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        drive0(1'b1, 4'hF, 4'hF, 1'b0);
        cycle("mode_u", 1'b1, 1'b0, 1'b1, 8'hE1, 1'b0);

        // Consume with nothing pending: valid drops, data retained
        drive0(1'b0, '0, '0, 1'b0);
        cycle("drain", 1'b0, 1'b0, 1'b0, 8'hE1, 1'b0);

        // Fresh reset, then continuous contention alternates 0,1,0,1
        rst_n = 1'b0;
        #1;
        check_eq("rst2.valid", 16'(res_valid), 16'd0);
        check_eq("rst2.res",   16'(res),       16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive0(1'b1, 4'h3, 4'h5, 1'b0);
        drive1(1'b1, 4'hE, 4'h3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) cycle($sformatf("rr%0d", i), 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0);
            else            cycle($sformatf("rr%0d", i), 1'b0, 1'b1, 1'b1, 8'hFA, 1'b1);
        end

        // Backpressure: slot holds requester 1's product, nobody granted
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            cycle($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1, 8'hFA, 1'b1);
        res_ready = 1'b1;
        cycle("unhold", 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0);

        // Asynchronous reset while a result is held
        res_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst.valid", 16'(res_valid), 16'd0);
        check_eq("arst.res",   16'(res),       16'd0);
        check_eq("arst.id",    16'(res_id),    16'd0);
        @(posedge clk);
        #1;
        check_eq("arst.hold_valid", 16'(res_valid), 16'd0);
        rst_n = 1'b1;
        res_ready = 1'b1;
        drive1(1'b1, 4'h2, 4'h7, 1'b0);
        cycle("post_rst", 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0);
        cycle("post_rst2", 1'b0, 1'b1, 1'b1, 8'h0E, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_share_arb2.md
Name: mul_share_arb2

Overview:
- Shares one signed/unsigned N-bit multiplier between two requesters.
- Each requester has a valid/ready request channel carrying its operands and a per-request sign mode.
- A round-robin arbiter grants one request per cycle into a single registered result slot.
- The result slot has a valid/ready output channel tagged with the requester id. The block sits between independent datapath clients and a single shared multiplier resource.

Parameters:
- n, 8, operand width in bits; each product is 2n bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_a  input  n  requester 0 operand a.
- req0_b  input  n  requester 0 operand b.
- req0_sign  input  1  requester 0 mode: 1 = two's-complement signed, 0 = unsigned.
- req1_valid  input  1  requester 1 has a request.
- req1_ready  output  1  requester 1 request accepted this cycle.
- req1_a  input  n  requester 1 operand a.
- req1_b  input  n  requester 1 operand b.
- req1_sign  input  1  requester 1 mode, same encoding as req0_sign.
- res_valid  output  1  result slot holds a product.
- res_ready  input  1  consumer takes the result.
- res  output  2n  product.
- res_id  output  1  requester that issued the product.

Behaviour:
- Reset (rst_n low, asynchronous): res_valid=0, res=0, res_id=0, priority pointer=0 (requester 0 preferred). Takes effect immediately. Any in-flight result is discarded.
- Slot free condition: free = !res_valid || res_ready.
- Grant (combinational from current inputs and state):
  - Only when free; at most one grant per cycle.
  - One valid requester: that requester is granted.
  - Both valid: the requester equal to the priority pointer is granted.
  - reqX_ready = grant to X. Ready may depend on valid; the requester must not make valid depend on ready.
- Handshake on the request side: a transfer occurs when reqX_valid && reqX_ready. Requesters hold valid, a, b and sign stable until the transfer. The block does not check this.
- Priority update: on any grant, the pointer becomes the other requester (last-granted loses priority). With no grant, the pointer is unchanged.
- Product width rules:
  - sign=1: both operands sign-extended to 2n, multiplied, low 2n bits kept. This equals the exact signed product.
  - sign=0: both operands zero-extended to 2n, multiplied, low 2n bits kept.
- Latency: request accepted at edge t appears as res_valid=1 with res/res_id valid after edge t, i.e. 1 cycle later.
- Result hold: while res_valid && !res_ready, res and res_id stay stable and no request is granted (both readies 0).
- Simultaneous consume and grant: when res_ready=1 and a request is granted in the same cycle, the slot is overwritten at the next edge and res_valid stays 1. This gives full throughput of one product per cycle.
- Consume without grant: res_ready=1 with no valid request clears res_valid at the next edge. res and res_id keep their last values.
- When res_valid=0, res_ready is ignored.
- Reset mid-stream: an outstanding result is dropped. A request presented during reset is not accepted. The first grant after release goes to requester 0 if both are valid.
- Boundaries for n=4:
  - signed -8*-8 = +64 (8'h40).
  - signed -8*7 = -56 (8'hC8).
  - unsigned 15*15 = 225 (8'hE1).
  - mode is per request: 4'hF * 4'hF gives 8'h01 signed and 8'hE1 unsigned.

Test Plan:
- Single requester, n=4: req0 a=4'hF, b=4'hF, sign=0, res_ready=1 → req0_ready=1 that cycle; next cycle res_valid=1, res=8'hE1, res_id=0.
- Signed extremes: req1 a=4'h8, b=4'h8, sign=1 → res=8'h40, res_id=1. Then a=4'h8, b=4'h7, sign=1 → res=8'hC8.
- Contention: both requests valid continuously after reset, res_ready=1 → grants alternate 0,1,0,1; res_id alternates the same way; one result per cycle with no bubbles.
- Backpressure: res_ready=0 while res_valid=1 with both requests pending → both readies 0; res/res_id stable for 5 cycles. Raising res_ready → new grant the same cycle; new result next cycle.
- Per-request mode: req0 4'hF*4'hF sign=1 followed by the same operands with sign=0 → results 8'h01 then 8'hE1.
- Reset mid-operation: res_valid=1 holding a result, assert rst_n=0 asynchronously → res_valid=0 and res=0 before the next edge. After release with both requests valid, the first grant goes to req0.
